hir_wr_port_drain: RTL and testbench
====================================

// Module: hir_wr_port_drain
// PURPOSE
//   Downstream sink for an HIR kernel memref write port (addr/wr_en/wr_data, e.g. the v2 port of Add).
//   Captures every kernel write into an internal DEPTH-entry buffer, tracking which entries were written.
//   On drain_start, streams written entries out in ascending address order over a valid/ready interface.
//   Replaces ad-hoc bench write checkers and feeds result comparison or host readback logic.
// PARAMETERS
//   ADDR_W  7    width of wr_addr/out_addr
//   DATA_W  64   width of wr_data/out_data
//   DEPTH   128  buffer entries; must equal 2**ADDR_W
// PORTS
//   clk         in   1       single clock, all logic on posedge
//   rst         in   1       synchronous, active-high reset
//   wr_addr     in   ADDR_W  kernel write address
//   wr_en       in   1       kernel write strobe, one write per cycle max
//   wr_data     in   DATA_W  kernel write data
//   drain_start in   1       one-cycle pulse: begin streaming captured entries
//   out_valid   out  1       out_addr/out_data/out_last valid
//   out_ready   in   1       consumer accepts when out_valid & out_ready
//   out_addr    out  ADDR_W  address of streamed entry
//   out_data    out  DATA_W  data of streamed entry
//   out_last    out  1       high with final written entry of the drain
//   wr_count    out  ADDR_W+1 number of distinct addresses written since last drain/reset
//   busy        out  1       high in DRAIN
//   done        out  1       one-cycle pulse when a drain completes
//   overwrite   out  1       one-cycle pulse, cycle after a write hits an already-written entry
//   wr_dropped  out  1       sticky: a write arrived during DRAIN; cleared only by rst
// BEHAVIOUR
//   Reset: state IDLE; all written bits 0; out_valid, out_last, busy, done, overwrite, wr_dropped,
//     wr_count = 0; out_addr/out_data = 0. Buffer data contents need not reset.
//   Storage: flop array DEPTH x DATA_W plus DEPTH written bits; wr_en at cycle N -> entry updated and
//     written bit set at N+1. Rewrite of a written entry: data replaced, wr_count unchanged, overwrite pulses.
//   States:
//     IDLE    -> CAPTURE on first wr_en; -> DRAIN on drain_start.
//     CAPTURE -> DRAIN on drain_start. Writes accepted in IDLE and CAPTURE.
//     DRAIN   scan pointer p from 0 upward, one address per cycle; skip unwritten entries (1 cycle each).
//             On written entry: load out_addr=p, out_data=mem[p], out_valid=1; out_last=1 iff no written
//             entry above p. Hold all outputs stable while out_valid & !out_ready.
//             After handshake with out_last=1 (or scan end with zero written entries): clear all written
//             bits, wr_count=0, done pulse, -> IDLE.
//   Latency: drain_start at cycle N -> busy at N+1; if entry 0 written, out_valid at N+2. After a
//     handshake, next out_valid no earlier than the following cycle (plus skipped entries).
//   Simultaneous wr_en and drain_start (IDLE/CAPTURE): write captured and included in the drain.
//   drain_start while in DRAIN: ignored. wr_en during DRAIN: dropped, wr_dropped set, buffer untouched.
//   Empty drain: no out_valid ever asserted; done pulses once scan reaches DEPTH-1.
//   Address DEPTH-1 written: pointer does not wrap; drain ends after that entry.
//   wr_count saturates naturally at DEPTH (ADDR_W+1 bits, no wrap).
//   rst mid-drain: outputs drop to reset values next cycle; no done pulse; partial stream abandoned.
// TESTING
//   Writes addr 3=5, 1=100, 7=9, then drain_start, out_ready=1 -> stream (1,100),(3,5),(7,9 last); done; wr_count 3->0.
//   Write addr 4 twice (data 1 then 2) -> overwrite pulse once, wr_count=1, drain yields (4,2,last).
//   Write all 128 addrs data=addr, drain with out_ready toggling 1/0 -> 128 beats in order, outputs stable on stall, last at 127.
//   drain_start with nothing written -> no out_valid, done pulse within 129 cycles, busy low after.
//   wr_en during DRAIN (addr 0, data 77) -> wr_dropped=1 stays set, stream unchanged.
//   rst asserted after 2 of 5 beats -> out_valid=0 next cycle, wr_count=0, new drain_start yields empty drain.

Source files
------------

// File: rtl/hir_wr_port_drain_if.sv
// Kernel memref write port plus the valid/ready drain stream, bundled between producer/consumer and the drain sink.
interface hir_wr_port_drain_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 64
);
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              drain_start;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_addr;
    logic [DATA_W-1:0] out_data;
    logic              out_last;

    modport master (
        output wr_addr, wr_en, wr_data, drain_start, out_ready,
        input  out_valid, out_addr, out_data, out_last
    );

    modport slave (
        input  wr_addr, wr_en, wr_data, drain_start, out_ready,
        output out_valid, out_addr, out_data, out_last
    );
endinterface

// File: rtl/hir_wr_port_drain.sv
// Captures kernel memref writes into a DEPTH-entry buffer and streams written entries in address order on drain.
// Write visible next cycle; first beat two cycles after drain_start; outputs held while out_valid & !out_ready.
module hir_wr_port_drain #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 64,
    parameter int DEPTH  = 128
) (
    input  logic              clk,
    input  logic              rst,
    hir_wr_port_drain_if.slave bus,
    output logic [ADDR_W:0]   wr_count,
    output logic              busy,
    output logic              done,
    output logic              overwrite,
    output logic              wr_dropped
);
    typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  written;
    logic [DEPTH-1:0]  above;
    logic [ADDR_W-1:0] ptr;
    logic              out_valid_q;
    logic              out_last_q;
    logic [ADDR_W-1:0] out_addr_q;
    logic [DATA_W-1:0] out_data_q;
    logic              accept_wr;
    logic              load;
    logic              advance;
    logic              finish;
    logic              none_above;

    assign above      = (written >> ptr) >> 1;
    assign none_above = ~|above;

    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_addr  = out_addr_q;
    assign bus.out_data  = out_data_q;
    assign busy          = (state == DRAIN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept_wr = 1'b0;
        load      = 1'b0;
        advance   = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                accept_wr = bus.wr_en;
                if (bus.drain_start) begin
                    state_nxt = DRAIN;
                end else if (bus.wr_en) begin
                    state_nxt = CAPTURE;
                end
            end
            CAPTURE: begin
                accept_wr = bus.wr_en;
                if (bus.drain_start) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                // The pointer only moves once the presented beat is accepted or the entry is empty.
                if (out_valid_q) begin
                    if (bus.out_ready) begin
                        if (out_last_q) begin
                            finish = 1'b1;
                        end else begin
                            advance = 1'b1;
                        end
                    end
                end else if (written[ptr]) begin
                    load = 1'b1;
                end else if (ptr == ADDR_W'(DEPTH - 1)) begin
                    finish = 1'b1;
                end else begin
                    advance = 1'b1;
                end
                if (finish) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Buffer data is never reset; the written bits alone decide what is valid.
    always_ff @(posedge clk) begin
        if (accept_wr) begin
            mem[bus.wr_addr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            written     <= '0;
            wr_count    <= '0;
            ptr         <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_addr_q  <= '0;
            out_data_q  <= '0;
            done        <= 1'b0;
            overwrite   <= 1'b0;
            wr_dropped  <= 1'b0;
        end else begin
            done      <= finish;
            overwrite <= accept_wr && written[bus.wr_addr];
            if (busy && bus.wr_en) begin
                wr_dropped <= 1'b1;
            end
            if (accept_wr) begin
                written[bus.wr_addr] <= 1'b1;
                if (!written[bus.wr_addr]) begin
                    wr_count <= wr_count + (ADDR_W + 1)'(1);
                end
            end
            if (load) begin
                out_valid_q <= 1'b1;
                out_addr_q  <= ptr;
                out_data_q  <= mem[ptr];
                out_last_q  <= none_above;
            end
            if (advance) begin
                ptr         <= ptr + ADDR_W'(1);
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
            end
            if (finish) begin
                written     <= '0;
                wr_count    <= '0;
                ptr         <= '0;
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_hir_wr_port_drain.sv
// Directed bench for hir_wr_port_drain: capture, overwrite, full drain with stalls, empty drain, dropped writes, reset mid-drain.
module tb_hir_wr_port_drain;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] wr_count;
    logic       busy;
    logic       done;
    logic       overwrite;
    logic       wr_dropped;

    int n_cmp = 0;
    int n_err = 0;

    logic [6:0]  b_addr [0:255];
    logic [63:0] b_data [0:255];
    logic        b_last [0:255];
    int          nbeats;
    int          valid_seen;
    int          stall_err;
    int          cyc_used;
    logic        got_done;
    logic        ow_seen;

    hir_wr_port_drain_if #(.ADDR_W(7), .DATA_W(64)) bus ();

    hir_wr_port_drain #(.ADDR_W(7), .DATA_W(64), .DEPTH(128)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .wr_count   (wr_count),
        .busy       (busy),
        .done       (done),
        .overwrite  (overwrite),
        .wr_dropped (wr_dropped)
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the write has landed.
    task automatic do_write(input logic [6:0] a, input logic [63:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
        @(negedge clk);
        bus.wr_en = 1'b0;
        ow_seen   = overwrite;
    endtask

    task automatic pulse_drain();
        bus.drain_start = 1'b1;
        @(negedge clk);
        bus.drain_start = 1'b0;
        chk_eq("busy_after_start", {63'd0, busy}, 64'd1);
    endtask

    // mode 0: ready always high; mode 1: ready toggles starting low.
    task automatic collect(input int mode, input int budget, input int max_beats);
        logic        have_stall;
        logic [6:0]  s_addr;
        logic [63:0] s_data;
        logic        s_last;
        nbeats     = 0;
        valid_seen = 0;
        stall_err  = 0;
        got_done   = 1'b0;
        cyc_used   = budget;
        have_stall = 1'b0;
        s_addr     = '0;
        s_data     = '0;
        s_last     = 1'b0;
        for (int c = 0; c < budget; c++) begin
            if (done) begin
                got_done = 1'b1;
                cyc_used = c;
                break;
            end
            if (max_beats > 0 && nbeats >= max_beats) begin
                cyc_used = c;
                break;
            end
            bus.out_ready = (mode == 0) ? 1'b1 : (c % 2 == 1);
            if (bus.out_valid) begin
                valid_seen++;
                if (have_stall && (bus.out_addr !== s_addr || bus.out_data !== s_data || bus.out_last !== s_last))
                    stall_err++;
                if (bus.out_ready) begin
                    b_addr[nbeats] = bus.out_addr;
                    b_data[nbeats] = bus.out_data;
                    b_last[nbeats] = bus.out_last;
                    nbeats++;
                    have_stall = 1'b0;
                end else begin
                    s_addr     = bus.out_addr;
                    s_data     = bus.out_data;
                    s_last     = bus.out_last;
                    have_stall = 1'b1;
                end
            end
            @(negedge clk);
        end
        bus.out_ready = 1'b0;
    endtask

    initial begin
        int ord_err;
        rst             = 1'b1;
        bus.wr_en       = 1'b0;
        bus.wr_addr     = '0;
        bus.wr_data     = '0;
        bus.drain_start = 1'b0;
        bus.out_ready   = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        chk_eq("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk_eq("rst_out_last", {63'd0, bus.out_last}, 64'd0);
        chk_eq("rst_out_addr", {57'd0, bus.out_addr}, 64'd0);
        chk_eq("rst_out_data", bus.out_data, 64'd0);
        chk_eq("rst_busy", {63'd0, busy}, 64'd0);
        chk_eq("rst_done", {63'd0, done}, 64'd0);
        chk_eq("rst_overwrite", {63'd0, overwrite}, 64'd0);
        chk_eq("rst_wr_dropped", {63'd0, wr_dropped}, 64'd0);
        chk_eq("rst_wr_count", {56'd0, wr_count}, 64'd0);

        // Three scattered writes, drained in ascending address order.
        do_write(7'd3, 64'd5);
        do_write(7'd1, 64'd100);
        do_write(7'd7, 64'd9);
        chk_eq("t1_wr_count", {56'd0, wr_count}, 64'd3);
        pulse_drain();
        collect(0, 100, 0);
        chk_eq("t1_nbeats", 64'(nbeats), 64'd3);
        chk_eq("t1_b0_addr", {57'd0, b_addr[0]}, 64'd1);
        chk_eq("t1_b0_data", b_data[0], 64'd100);
        chk_eq("t1_b0_last", {63'd0, b_last[0]}, 64'd0);
        chk_eq("t1_b1_addr", {57'd0, b_addr[1]}, 64'd3);
        chk_eq("t1_b1_data", b_data[1], 64'd5);
        chk_eq("t1_b1_last", {63'd0, b_last[1]}, 64'd0);
        chk_eq("t1_b2_addr", {57'd0, b_addr[2]}, 64'd7);
        chk_eq("t1_b2_data", b_data[2], 64'd9);
        chk_eq("t1_b2_last", {63'd0, b_last[2]}, 64'd1);
        chk_eq("t1_done", {63'd0, got_done}, 64'd1);
        chk_eq("t1_wr_count_after", {56'd0, wr_count}, 64'd0);
        chk_eq("t1_busy_after", {63'd0, busy}, 64'd0);
        @(negedge clk);
        chk_eq("t1_done_one_cycle", {63'd0, done}, 64'd0);

        // Rewrite of one entry.
        do_write(7'd4, 64'd1);
        chk_eq("t2_ow_first", {63'd0, ow_seen}, 64'd0);
        do_write(7'd4, 64'd2);
        chk_eq("t2_ow_second", {63'd0, ow_seen}, 64'd1);
        @(negedge clk);
        chk_eq("t2_ow_pulse_end", {63'd0, overwrite}, 64'd0);
        chk_eq("t2_wr_count", {56'd0, wr_count}, 64'd1);
        pulse_drain();
        collect(0, 200, 0);
        chk_eq("t2_nbeats", 64'(nbeats), 64'd1);
        chk_eq("t2_addr", {57'd0, b_addr[0]}, 64'd4);
        chk_eq("t2_data", b_data[0], 64'd2);
        chk_eq("t2_last", {63'd0, b_last[0]}, 64'd1);
        chk_eq("t2_done", {63'd0, got_done}, 64'd1);

        // Full buffer, toggling ready.
        for (int i = 0; i < 128; i++) do_write(7'(i), 64'(i));
        chk_eq("t3_wr_count", {56'd0, wr_count}, 64'd128);
        pulse_drain();
        chk_eq("t3_valid_n1", {63'd0, bus.out_valid}, 64'd0);
        @(negedge clk);
        chk_eq("t3_valid_n2", {63'd0, bus.out_valid}, 64'd1);
        collect(1, 1500, 0);
        chk_eq("t3_nbeats", 64'(nbeats), 64'd128);
        ord_err = 0;
        for (int i = 0; i < nbeats; i++) begin
            if (b_addr[i] !== 7'(i) || b_data[i] !== 64'(i) || b_last[i] !== (i == 127)) ord_err++;
        end
        chk_eq("t3_order", 64'(ord_err), 64'd0);
        chk_eq("t3_stall_stable", 64'(stall_err), 64'd0);
        chk_eq("t3_done", {63'd0, got_done}, 64'd1);
        chk_eq("t3_wr_count_after", {56'd0, wr_count}, 64'd0);

        // Empty drain.
        pulse_drain();
        collect(0, 140, 0);
        chk_eq("t4_no_valid", 64'(valid_seen), 64'd0);
        chk_eq("t4_done", {63'd0, got_done}, 64'd1);
        chk_eq("t4_done_in_time", {63'd0, cyc_used <= 129}, 64'd1);
        chk_eq("t4_busy_after", {63'd0, busy}, 64'd0);

        // Write arriving during a drain is dropped.
        do_write(7'd2, 64'd20);
        do_write(7'd6, 64'd60);
        pulse_drain();
        bus.wr_en   = 1'b1;
        bus.wr_addr = 7'd0;
        bus.wr_data = 64'd77;
        @(negedge clk);
        bus.wr_en = 1'b0;
        chk_eq("t5_dropped_set", {63'd0, wr_dropped}, 64'd1);
        chk_eq("t5_count_kept", {56'd0, wr_count}, 64'd2);
        collect(0, 200, 0);
        chk_eq("t5_nbeats", 64'(nbeats), 64'd2);
        chk_eq("t5_b0_addr", {57'd0, b_addr[0]}, 64'd2);
        chk_eq("t5_b0_data", b_data[0], 64'd20);
        chk_eq("t5_b1_addr", {57'd0, b_addr[1]}, 64'd6);
        chk_eq("t5_b1_data", b_data[1], 64'd60);
        chk_eq("t5_b1_last", {63'd0, b_last[1]}, 64'd1);
        chk_eq("t5_dropped_sticky", {63'd0, wr_dropped}, 64'd1);

        // Reset in the middle of a drain.
        for (int i = 0; i < 5; i++) do_write(7'(10 + i), 64'(200 + i));
        pulse_drain();
        collect(0, 100, 2);
        chk_eq("t6_partial_beats", 64'(nbeats), 64'd2);
        chk_eq("t6_b1_addr", {57'd0, b_addr[1]}, 64'd11);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_eq("t6_valid_dropped", {63'd0, bus.out_valid}, 64'd0);
        chk_eq("t6_wr_count", {56'd0, wr_count}, 64'd0);
        chk_eq("t6_busy", {63'd0, busy}, 64'd0);
        chk_eq("t6_no_done", {63'd0, done}, 64'd0);
        chk_eq("t6_dropped_cleared", {63'd0, wr_dropped}, 64'd0);
        @(negedge clk);
        pulse_drain();
        collect(0, 140, 0);
        chk_eq("t6_empty_no_valid", 64'(valid_seen), 64'd0);
        chk_eq("t6_empty_done", {63'd0, got_done}, 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
